// File: rtl/byte_word_loader.sv
// rtl/byte_word_loader.sv - byte stream to 32-bit little-endian word RAM loader
//
// Packs bytes accepted on a valid/ready handshake into 32-bit words (first
// byte -> bits [7:0]) and writes each word to a word-wide RAM at
// auto-incrementing addresses starting from base_addr.
//
// Optional feature macro: LOADER_CHECKSUM_EN (running sum of written words).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_start           pulse: begin frame, load address from base_addr
//   frame_end             pulse: end frame, flush any partial word
//   base_addr             first word address of the frame
//   byte_valid/byte_data  incoming byte stream
//   byte_ready            loader accepts a byte this cycle
//   mem_we/addr/data      RAM write port, one strobe per word
//   word_count            words written in the current frame (saturating)
//   done                  one-cycle pulse when the frame is committed
//   overflow              sticky: address wrapped during this frame
//   checksum              running word sum (0 when feature disabled)

module byte_word_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              overflow,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W:0]   WC_ONE   = 1;
    localparam logic [ADDR_W:0]   WC_MAX   = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        idx;
    logic [31:0]       pack;
    logic              end_pending;
    logic              accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; frame_start anywhere restarts the frame
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (frame_start) begin
                    state_nxt = S_COLLECT;
                end else if (accept && idx == 2'd3) begin
                    // End arriving with the completing byte is latched in end_pending
                    state_nxt = S_WRITE;
                end else if (frame_end) begin
                    // Accepted byte is taken first, so the word is non-empty
                    state_nxt = (accept || idx != 2'd0) ? S_FLUSH : S_DONE;
                end
            end
            S_WRITE: begin
                if (frame_start) begin
                    state_nxt = S_COLLECT;
                end else if (end_pending || frame_end) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
            S_FLUSH: begin
                state_nxt = frame_start ? S_COLLECT : S_DONE;
            end
            S_DONE: begin
                state_nxt = frame_start ? S_COLLECT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        byte_ready = (state == S_COLLECT);
        mem_we     = (state == S_WRITE) || (state == S_FLUSH);
        done       = (state == S_DONE);
        accept     = byte_valid && byte_ready;
    end

    // Datapath: packing register, address, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            idx         <= 2'd0;
            pack        <= 32'h0;
            word_count  <= '0;
            overflow    <= 1'b0;
            end_pending <= 1'b0;
        end else if (frame_start) begin
            addr        <= base_addr;
            idx         <= 2'd0;
            pack        <= 32'h0;
            word_count  <= '0;
            overflow    <= 1'b0;
            end_pending <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (accept) begin
                        pack[{idx, 3'b000} +: 8] <= byte_data;
                        idx                      <= idx + 2'd1;
                        if (idx == 2'd3) end_pending <= frame_end;
                    end
                end
                S_WRITE, S_FLUSH: begin
                    addr <= addr + ADDR_ONE;
                    if (addr == ADDR_MAX) overflow <= 1'b1;
                    if (word_count != WC_MAX) word_count <= word_count + WC_ONE;
                    idx         <= 2'd0;
                    pack        <= 32'h0;
                    end_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = addr;
    // Unfilled upper bytes of a flushed word are zero because pack is cleared per word
    assign mem_data = pack;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            sum_q <= 32'h0;
        end else if (mem_we) begin
            sum_q <= sum_q + pack;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_byte_word_loader.sv
// tb/tb_byte_word_loader.sv - self-checking bench for byte_word_loader

module tb_byte_word_loader;

    localparam int ADDR_W = 5;
    localparam int NWORDS = 1 << ADDR_W;
    localparam int WC_SAT = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              frame_end;
    logic [ADDR_W-1:0] base_addr;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              overflow;
    logic [31:0]       checksum;

    byte_word_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .base_addr   (base_addr),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .word_count  (word_count),
        .done        (done),
        .overflow    (overflow),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    // Observed RAM writes and done pulses, sampled mid-cycle
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_total = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(mem_data);
            end
            if (done) done_total = done_total + 1;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sent_q[$];
    int          wr_base   = 0;
    int          done_base = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int b);
        frame_start = 1'b1;
        base_addr   = ADDR_W'(b);
        tick();
        frame_start = 1'b0;
        sent_q.delete();
        wr_base   = wr_addr_q.size();
        done_base = done_total;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit with_end, input int gap);
        bit took;
        took = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        byte_valid = 1'b1;
        byte_data  = d;
        for (int k = 0; k < 32; k++) begin
            took      = byte_ready;
            frame_end = with_end & took;
            tick();
            if (took) break;
        end
        byte_valid = 1'b0;
        frame_end  = 1'b0;
        byte_data  = 8'hXX;
        if (took) sent_q.push_back(d);
        else chk("byte_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Reference: words are the sent bytes grouped by four, little-endian,
    // zero-padded, written to consecutive addresses modulo the RAM size.
    task automatic check_frame(input string tag, input int base);
        int          n, nw, a, nobs;
        logic [31:0] w, sum;
        bit          ovf;
        n   = sent_q.size();
        nw  = (n + 3) / 4;
        sum = 32'h0;
        ovf = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_total != done_base) break;
            tick();
        end
        tick();
        tick();
        chk({tag, "_done_pulses"}, 64'(done_total - done_base), 64'(1));
        nobs = wr_addr_q.size() - wr_base;
        chk({tag, "_num_writes"}, 64'(nobs), 64'(nw));
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * i + b < n) w = w | (32'(sent_q[4 * i + b]) << (8 * b));
            a   = (base + i) % NWORDS;
            sum = sum + w;
            if (a == NWORDS - 1) ovf = 1'b1;
            if (i < nobs) begin
                chk({tag, "_addr"}, 64'(wr_addr_q[wr_base + i]), 64'(a));
                chk({tag, "_data"}, 64'(wr_data_q[wr_base + i]), 64'(w));
            end
        end
        chk({tag, "_word_count"}, 64'(word_count), 64'((nw > WC_SAT) ? WC_SAT : nw));
        chk({tag, "_final_addr"}, 64'(mem_addr), 64'((base + nw) % NWORDS));
        chk({tag, "_overflow"}, 64'(overflow), 64'(ovf));
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, 64'(checksum), 64'(sum));
`else
        chk({tag, "_checksum"}, 64'(checksum), 64'(0));
`endif
        chk({tag, "_idle_ready"}, 64'(byte_ready), 64'(0));
    endtask

    initial begin
        int          base, n;
        bit          end_last;
        logic [7:0]  d;

        rst         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        base_addr   = '0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 64'(byte_ready), 64'(0));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_data", 64'(mem_data), 64'(0));
        chk("rst_wc", 64'(word_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_sum", 64'(checksum), 64'(0));
        rst = 1'b0;
        tick();

        // frame_end in IDLE is ignored
        send_end();
        tick();
        chk("idle_end_done", 64'(done_total), 64'(0));

        // Test 1: four back-to-back bytes, exact write latency
        pulse_start(3);
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d         = 8'(8'h11 * (i + 1));
            byte_data = d;
            chk("t1_ready", 64'(byte_ready), 64'(1));
            sent_q.push_back(d);
            tick();
        end
        byte_valid = 1'b0;
        chk("t1_we", 64'(mem_we), 64'(1));
        chk("t1_addr", 64'(mem_addr), 64'(3));
        chk("t1_data", 64'(mem_data), 64'(32'h44332211));
        chk("t1_ready_in_write", 64'(byte_ready), 64'(0));
        tick();
        chk("t1_we_after", 64'(mem_we), 64'(0));
        chk("t1_ready_after", 64'(byte_ready), 64'(1));
        send_end();
        check_frame("t1", 3);

        // Test 2: two words then frame_end (lands in the WRITE cycle)
        pulse_start(3);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 0);
        send_end();
        check_frame("t2", 3);
`ifdef LOADER_CHECKSUM_EN
        chk("t6_checksum", 64'(checksum), 64'(32'h0C0A0806));
`else
        chk("t6_checksum", 64'(checksum), 64'(0));
`endif

        // Test 3: partial word flush
        pulse_start(3);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_end();
        check_frame("t3", 3);

        // Test 4: wrap past the top address
        pulse_start(31);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 0);
        send_end();
        check_frame("t4", 31);
        pulse_start(0);
        chk("t4_ovf_cleared", 64'(overflow), 64'(0));
        send_end();
        check_frame("t4_empty", 0);

        // Test 5: restart after two bytes discards them
        pulse_start(7);
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h66, 1'b0, 0);
        pulse_start(10);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 0);
        send_end();
        check_frame("t5", 10);

        // frame_end together with the completing byte, and with a partial byte
        pulse_start(20);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), (i == 3), 0);
        check_frame("end_with_word", 20);
        pulse_start(21);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hD0 + i), (i == 2), 1);
        check_frame("end_with_partial", 21);

        // word_count saturation over a long wrapping frame
        pulse_start(0);
        for (int i = 0; i < 4 * (WC_SAT + 2); i++) send_byte(8'(i * 7 + 3), 1'b0, 0);
        send_end();
        check_frame("saturate", 0);

        // Reset mid-frame suppresses the pending write
        pulse_start(5);
        for (int i = 0; i < 3; i++) send_byte(8'(i), 1'b0, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        rst        = 1'b1;
        tick();
        byte_valid = 1'b0;
        chk("midrst_we", 64'(mem_we), 64'(0));
        chk("midrst_ready", 64'(byte_ready), 64'(0));
        chk("midrst_wc", 64'(word_count), 64'(0));
        rst = 1'b0;
        tick();
        chk("midrst_we_after", 64'(mem_we), 64'(0));
        chk("midrst_ready_after", 64'(byte_ready), 64'(0));

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            base     = int'($urandom_range(0, NWORDS - 1));
            n        = int'($urandom_range(0, 22));
            end_last = ($urandom_range(0, 1) == 1) && (n > 0);
            pulse_start(base);
            for (int i = 0; i < n; i++)
                send_byte(8'($urandom_range(0, 255)), end_last && (i == n - 1),
                          int'($urandom_range(0, 2)));
            if (!end_last) send_end();
            check_frame("rand", base);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
